// File: rtl/invader_pkg.sv
// Shared types and constants for the invader march controller: state encoding,
// speed ceiling, frame-counter and pixel-coordinate widths, and the step-period helper.
package invader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARCH_R,
        ST_DESC_L,
        ST_MARCH_L,
        ST_DESC_R,
        ST_CLEARED,
        ST_LANDED
    } march_state_t;

    localparam int SPEED_LVL_MAX = 15;
    localparam int SPEED_W       = 4;
    localparam int FRAME_W       = 8;
    localparam int COORD_W       = 11;

    // max(base - speed*dec, min_p), evaluated without unsigned wrap.
    function automatic logic [FRAME_W-1:0] calc_period(
        input logic [SPEED_W-1:0] speed,
        input int                 base,
        input int                 dec,
        input int                 min_p
    );
        int reduction;
        reduction = int'(speed) * dec;
        if (reduction + min_p >= base)
            return FRAME_W'(min_p);
        else
            return FRAME_W'(base - reduction);
    endfunction

endpackage

// File: rtl/march_frame_timer.sv
// Frame counter shared by march stepping and descend timing: counts startOfFrame
// ticks and flags the tick that completes the requested period.
module march_frame_timer
    import invader_pkg::*;
(
    input  logic               clk,
    input  logic               resetN,
    input  logic               i_clear,
    input  logic               i_tick,
    input  logic [FRAME_W-1:0] i_period,
    output logic               o_tc
);

    logic [FRAME_W-1:0] r_cnt;
    logic               w_last;

    // ">=" rather than "==" so a period that shrinks mid-count still terminates promptly.
    assign w_last = ({1'b0, r_cnt} + {{FRAME_W{1'b0}}, 1'b1}) >= {1'b0, i_period};
    assign o_tc   = i_tick && w_last;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            r_cnt <= '0;
        else if (i_clear || o_tc)
            r_cnt <= '0;
        else if (i_tick)
            r_cnt <= r_cnt + FRAME_W'(1);
    end

endmodule

// File: rtl/invader_march_ctrl.sv
// Invader formation march sequencer: step timing, edge reversal, descend phases, speed-up on kills.
// Optional INVADER_MARCH_FINAL_SPRINT_EN: the last surviving invader marches at MIN_PERIOD.
module invader_march_ctrl
    import invader_pkg::*;
#(
    parameter int NUM_INVADERS    = 32,
    parameter int BASE_PERIOD     = 30,
    parameter int PERIOD_DEC      = 2,
    parameter int MIN_PERIOD      = 2,
    parameter int KILLS_PER_LEVEL = 4,
    parameter int DESCEND_FRAMES  = 30,
    parameter int FLOOR_Y         = 400,
    localparam int ALIVE_W        = $clog2(NUM_INVADERS + 1)
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               i_startOfFrame,
    input  logic               i_startWave,
    input  logic               i_invaderHit,
    input  logic               i_hitRight,
    input  logic               i_hitLeft,
    input  logic [COORD_W-1:0] i_formationBottomY,
    output logic               o_stepPulse,
    output logic               o_chgDir,
    output logic               o_descending,
    output logic               o_movingRight,
    output logic [SPEED_W-1:0] o_speedLevel,
    output logic [ALIVE_W-1:0] o_aliveCount,
    output logic               o_waveCleared,
    output logic               o_invadersLanded
);

    localparam int KILL_W = $clog2(KILLS_PER_LEVEL + 1);

    march_state_t       r_state, w_state_next;
    logic               r_step, r_chg, r_desc, r_right, r_cleared, r_landed;
    logic [SPEED_W-1:0] r_speed;
    logic [ALIVE_W-1:0] r_alive;
    logic [KILL_W-1:0]  r_kills;

    logic               w_step_next, w_chg_next, w_timer_clr, w_tc;
    logic               w_march, w_desc, w_hit_ok, w_clear_now, w_landed_now, w_edge;
    logic [FRAME_W-1:0] w_period, w_timer_period;

    assign w_march      = (r_state == ST_MARCH_R) || (r_state == ST_MARCH_L);
    assign w_desc       = (r_state == ST_DESC_L)  || (r_state == ST_DESC_R);
    assign w_hit_ok     = i_invaderHit && (r_alive != '0) && !i_startWave;
    assign w_clear_now  = w_hit_ok && (r_alive == ALIVE_W'(1));
    assign w_landed_now = i_formationBottomY >= COORD_W'(FLOOR_Y);
    assign w_edge       = ((r_state == ST_MARCH_R) && i_hitRight) ||
                          ((r_state == ST_MARCH_L) && i_hitLeft);

`ifdef INVADER_MARCH_FINAL_SPRINT_EN
    assign w_period = (r_alive == ALIVE_W'(1)) ? FRAME_W'(MIN_PERIOD)
                    : calc_period(r_speed, BASE_PERIOD, PERIOD_DEC, MIN_PERIOD);
`else
    assign w_period = calc_period(r_speed, BASE_PERIOD, PERIOD_DEC, MIN_PERIOD);
`endif

    assign w_timer_period = w_desc ? FRAME_W'(DESCEND_FRAMES) : w_period;

    march_frame_timer u_timer (
        .clk      (clk),
        .resetN   (resetN),
        .i_clear  (w_timer_clr),
        .i_tick   (i_startOfFrame),
        .i_period (w_timer_period),
        .o_tc     (w_tc)
    );

    // Priority: startWave > cleared > landed > edge reversal > step / descend timing.
    always_comb begin
        w_state_next = r_state;
        w_step_next  = 1'b0;
        w_chg_next   = 1'b0;
        w_timer_clr  = 1'b0;
        if (i_startWave) begin
            w_state_next = ST_MARCH_R;
            w_timer_clr  = 1'b1;
        end else if (w_march || w_desc) begin
            if (w_clear_now) begin
                w_state_next = ST_CLEARED;
                w_timer_clr  = 1'b1;
            end else if (w_landed_now) begin
                w_state_next = ST_LANDED;
                w_timer_clr  = 1'b1;
            end else if (w_march) begin
                if (w_edge) begin
                    w_state_next = (r_state == ST_MARCH_R) ? ST_DESC_L : ST_DESC_R;
                    w_chg_next   = 1'b1;
                    w_timer_clr  = 1'b1;
                end else begin
                    w_step_next = w_tc;
                end
            end else begin
                w_step_next = i_startOfFrame;
                if (w_tc)
                    w_state_next = (r_state == ST_DESC_L) ? ST_MARCH_L : ST_MARCH_R;
            end
        end else begin
            w_timer_clr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state   <= ST_IDLE;
            r_step    <= 1'b0;
            r_chg     <= 1'b0;
            r_desc    <= 1'b0;
            r_right   <= 1'b0;
            r_cleared <= 1'b0;
            r_landed  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_step    <= w_step_next;
            r_chg     <= w_chg_next;
            r_desc    <= (w_state_next == ST_DESC_L) || (w_state_next == ST_DESC_R);
            r_cleared <= (w_state_next == ST_CLEARED);
            r_landed  <= (w_state_next == ST_LANDED);
            if (i_startWave)
                r_right <= 1'b1;
            else if (w_chg_next)
                r_right <= ~r_right;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_alive <= '0;
            r_kills <= '0;
            r_speed <= '0;
        end else if (i_startWave) begin
            r_alive <= ALIVE_W'(NUM_INVADERS);
            r_kills <= '0;
            r_speed <= '0;
        end else if (w_hit_ok) begin
            r_alive <= r_alive - ALIVE_W'(1);
            if (r_kills == KILL_W'(KILLS_PER_LEVEL - 1)) begin
                r_kills <= '0;
                if (r_speed != SPEED_W'(SPEED_LVL_MAX))
                    r_speed <= r_speed + SPEED_W'(1);
            end else begin
                r_kills <= r_kills + KILL_W'(1);
            end
        end
    end

    assign o_stepPulse      = r_step;
    assign o_chgDir         = r_chg;
    assign o_descending     = r_desc;
    assign o_movingRight    = r_right;
    assign o_speedLevel     = r_speed;
    assign o_aliveCount     = r_alive;
    assign o_waveCleared    = r_cleared;
    assign o_invadersLanded = r_landed;

endmodule

// File: tb/tb_invader_march_ctrl.sv
// Self-checking bench for invader_march_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a phase/direction level reference model.
module tb_invader_march_ctrl;

    localparam int P_IDLE = 0, P_MARCH = 1, P_DESC = 2, P_CLEARED = 3, P_LANDED = 4;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        i_sof = 1'b0, i_sw = 1'b0, i_hit = 1'b0, i_hr = 1'b0, i_hl = 1'b0;
    logic [10:0] i_y = '0;
    logic        o_step, o_chg, o_desc, o_right, o_cleared, o_landed;
    logic [3:0]  o_speed;
    logic [5:0]  o_alive;

    int total = 0;
    int bad   = 0;

    int m_phase, m_alive, m_kills, m_speed, m_frames;
    bit m_right, m_step, m_chg;
    int steps_seen, steps_exp, chg_seen;

    always #5 clk = ~clk;

    invader_march_ctrl dut (
        .clk                (clk),
        .resetN             (resetN),
        .i_startOfFrame     (i_sof),
        .i_startWave        (i_sw),
        .i_invaderHit       (i_hit),
        .i_hitRight         (i_hr),
        .i_hitLeft          (i_hl),
        .i_formationBottomY (i_y),
        .o_stepPulse        (o_step),
        .o_chgDir           (o_chg),
        .o_descending       (o_desc),
        .o_movingRight      (o_right),
        .o_speedLevel       (o_speed),
        .o_aliveCount       (o_alive),
        .o_waveCleared      (o_cleared),
        .o_invadersLanded   (o_landed)
    );

    task automatic model_reset();
        m_phase = P_IDLE; m_alive = 0; m_kills = 0; m_speed = 0; m_frames = 0;
        m_right = 1'b0; m_step = 1'b0; m_chg = 1'b0;
    endtask

    // One clock of the game rules, using the values held before this clock.
    task automatic model_step(input bit sof, input bit sw, input bit hit,
                              input bit hr, input bit hl, input int y);
        int period;
        bit cleared_now;
        m_step = 1'b0;
        m_chg  = 1'b0;
        if (sw) begin
            m_phase = P_MARCH; m_right = 1'b1; m_alive = 32;
            m_speed = 0; m_kills = 0; m_frames = 0;
            return;
        end
        period = 30 - m_speed * 2;
        if (period < 2) period = 2;
`ifdef INVADER_MARCH_FINAL_SPRINT_EN
        if (m_alive == 1) period = 2;
`endif
        cleared_now = 1'b0;
        if (hit && m_alive > 0) begin
            m_alive--;
            m_kills++;
            if (m_kills == 4) begin
                m_kills = 0;
                if (m_speed < 15) m_speed++;
            end
            if (m_alive == 0) cleared_now = 1'b1;
        end
        if (m_phase == P_MARCH || m_phase == P_DESC) begin
            if (cleared_now) m_phase = P_CLEARED;
            else if (y >= 400) m_phase = P_LANDED;
            else if (m_phase == P_MARCH) begin
                if ((m_right && hr) || (!m_right && hl)) begin
                    m_phase = P_DESC; m_right = !m_right; m_chg = 1'b1; m_frames = 0;
                end else if (sof) begin
                    m_frames++;
                    if (m_frames >= period) begin m_step = 1'b1; m_frames = 0; end
                end
            end else if (sof) begin
                m_step = 1'b1;
                m_frames++;
                if (m_frames == 30) begin m_phase = P_MARCH; m_frames = 0; end
            end
        end
    endtask

    task automatic tick(input bit sof, input bit sw, input bit hit,
                        input bit hr, input bit hl, input int y);
        @(negedge clk);
        i_sof = sof; i_sw = sw; i_hit = hit; i_hr = hr; i_hl = hl; i_y = y[10:0];
        @(posedge clk);
        model_step(sof, sw, hit, hr, hl, y);
        #1;
        if (o_step) steps_seen++;
        if (o_chg) chg_seen++;
        if (m_step) steps_exp++;
    endtask

    task automatic run_frames(input int n, input bit hr, input bit hl, input int y);
        for (int f = 0; f < n; f++) begin
            tick(1'b1, 1'b0, 1'b0, hr, hl, y);
            for (int g = 0; g < 3; g++) tick(1'b0, 1'b0, 1'b0, hr, hl, y);
        end
    endtask

    task automatic clear_counts();
        steps_seen = 0; steps_exp = 0; chg_seen = 0;
    endtask

    task automatic test_reset();
        total += 8;
        if (o_step !== 1'b0)    begin bad++; $display("FAIL reset_step got=%b want=0", o_step); end
        if (o_chg !== 1'b0)     begin bad++; $display("FAIL reset_chg got=%b want=0", o_chg); end
        if (o_desc !== 1'b0)    begin bad++; $display("FAIL reset_desc got=%b want=0", o_desc); end
        if (o_right !== 1'b0)   begin bad++; $display("FAIL reset_right got=%b want=0", o_right); end
        if (o_speed !== 4'd0)   begin bad++; $display("FAIL reset_speed got=%0d want=0", o_speed); end
        if (o_alive !== 6'd0)   begin bad++; $display("FAIL reset_alive got=%0d want=0", o_alive); end
        if (o_cleared !== 1'b0) begin bad++; $display("FAIL reset_cleared got=%b want=0", o_cleared); end
        if (o_landed !== 1'b0)  begin bad++; $display("FAIL reset_landed got=%b want=0", o_landed); end
        $display("test_reset: outputs checked after reset");
    endtask

    task automatic test_march();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        clear_counts();
        run_frames(60, 1'b0, 1'b0, 0);
        total += 4;
        if (steps_seen !== steps_exp) begin bad++; $display("FAIL march_steps got=%0d want=%0d", steps_seen, steps_exp); end
        if (steps_seen !== 2) begin bad++; $display("FAIL march_steps_spec got=%0d want=2", steps_seen); end
        if (o_right !== m_right) begin bad++; $display("FAIL march_right got=%b want=%b", o_right, m_right); end
        if (o_alive !== 6'(m_alive)) begin bad++; $display("FAIL march_alive got=%0d want=%0d", o_alive, m_alive); end
        $display("test_march: 60 frames, steps=%0d", steps_seen);
    endtask

    task automatic test_speed();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int k = 0; k < 8; k++) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        total += 1;
        if (o_speed !== 4'(m_speed)) begin bad++; $display("FAIL speed_level got=%0d want=%0d", o_speed, m_speed); end
        clear_counts();
        run_frames(26, 1'b0, 1'b0, 0);
        total += 2;
        if (steps_seen !== steps_exp) begin bad++; $display("FAIL speed_steps got=%0d want=%0d", steps_seen, steps_exp); end
        if (steps_seen !== 1) begin bad++; $display("FAIL speed_steps_spec got=%0d want=1", steps_seen); end
        $display("test_speed: speed=%0d steps in 26 frames=%0d", o_speed, steps_seen);
    endtask

    task automatic test_edge();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run_frames(5, 1'b0, 1'b0, 0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        total += 2;
        if (o_chg !== 1'b1)  begin bad++; $display("FAIL edge_chg got=%b want=1", o_chg); end
        if (o_desc !== 1'b1) begin bad++; $display("FAIL edge_desc got=%b want=1", o_desc); end
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        total += 1;
        if (o_chg !== 1'b0) begin bad++; $display("FAIL edge_chg_pulse got=%b want=0", o_chg); end
        clear_counts();
        run_frames(30, 1'b1, 1'b0, 0);
        total += 5;
        if (steps_seen !== steps_exp) begin bad++; $display("FAIL desc_steps got=%0d want=%0d", steps_seen, steps_exp); end
        if (steps_seen !== 30) begin bad++; $display("FAIL desc_steps_spec got=%0d want=30", steps_seen); end
        if (chg_seen !== 0) begin bad++; $display("FAIL desc_ignore_edge got=%0d want=0", chg_seen); end
        if (o_right !== 1'b0) begin bad++; $display("FAIL desc_right got=%b want=0", o_right); end
        if (o_desc !== 1'b0) begin bad++; $display("FAIL desc_done got=%b want=0", o_desc); end
        $display("test_edge: descend steps=%0d movingRight=%b", steps_seen, o_right);
    endtask

    task automatic test_clear();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int k = 0; k < 32; k++) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        total += 3;
        if (o_alive !== 6'd0)   begin bad++; $display("FAIL clear_alive got=%0d want=0", o_alive); end
        if (o_cleared !== 1'b1) begin bad++; $display("FAIL clear_flag got=%b want=1", o_cleared); end
        if (o_speed !== 4'(m_speed)) begin bad++; $display("FAIL clear_speed got=%0d want=%0d", o_speed, m_speed); end
        clear_counts();
        run_frames(40, 1'b0, 1'b0, 0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        total += 3;
        if (steps_seen !== 0) begin bad++; $display("FAIL clear_no_step got=%0d want=0", steps_seen); end
        if (o_alive !== 6'd0) begin bad++; $display("FAIL clear_extra_hit got=%0d want=0", o_alive); end
        if (o_desc !== 1'b0) begin bad++; $display("FAIL clear_desc got=%b want=0", o_desc); end
        $display("test_clear: alive=%0d cleared=%b", o_alive, o_cleared);
    endtask

    task automatic test_landed();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        run_frames(30, 1'b0, 1'b0, 0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 399);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 400);
        total += 2;
        if (o_landed !== 1'b1) begin bad++; $display("FAIL landed_flag got=%b want=1", o_landed); end
        if (o_alive !== 6'(m_alive)) begin bad++; $display("FAIL landed_alive got=%0d want=%0d", o_alive, m_alive); end
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 400);
        total += 4;
        if (o_landed !== 1'b0) begin bad++; $display("FAIL restart_landed got=%b want=0", o_landed); end
        if (o_right !== 1'b1)  begin bad++; $display("FAIL restart_right got=%b want=1", o_right); end
        if (o_alive !== 6'd32) begin bad++; $display("FAIL restart_alive got=%0d want=32", o_alive); end
        if (o_speed !== 4'd0)  begin bad++; $display("FAIL restart_speed got=%0d want=0", o_speed); end
        $display("test_landed: relaunched alive=%0d", o_alive);
    endtask

    task automatic test_random();
        int y;
        bit sof, sw, hit, hr, hl;
        int local_bad;
        local_bad = 0;
        hr = 1'b0; hl = 1'b0;
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int c = 0; c < 6000; c++) begin
            sof = ($urandom_range(0, 2) == 0);
            sw  = ($urandom_range(0, 799) == 0);
            hit = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 60) == 0) hr = ~hr;
            if ($urandom_range(0, 60) == 0) hl = ~hl;
            y = ($urandom_range(0, 1499) == 0) ? $urandom_range(400, 700) : $urandom_range(0, 399);
            if (m_phase == P_CLEARED || m_phase == P_LANDED) sw = ($urandom_range(0, 19) == 0);
            tick(sof, sw, hit, hr, hl, y);
            total += 8;
            if (o_step !== m_step) begin bad++; local_bad++; $display("FAIL rnd_step cyc=%0d got=%b want=%b", c, o_step, m_step); end
            if (o_chg !== m_chg) begin bad++; local_bad++; $display("FAIL rnd_chg cyc=%0d got=%b want=%b", c, o_chg, m_chg); end
            if (o_desc !== (m_phase == P_DESC)) begin bad++; local_bad++; $display("FAIL rnd_desc cyc=%0d got=%b", c, o_desc); end
            if (o_right !== m_right) begin bad++; local_bad++; $display("FAIL rnd_right cyc=%0d got=%b want=%b", c, o_right, m_right); end
            if (o_speed !== 4'(m_speed)) begin bad++; local_bad++; $display("FAIL rnd_speed cyc=%0d got=%0d want=%0d", c, o_speed, m_speed); end
            if (o_alive !== 6'(m_alive)) begin bad++; local_bad++; $display("FAIL rnd_alive cyc=%0d got=%0d want=%0d", c, o_alive, m_alive); end
            if (o_cleared !== (m_phase == P_CLEARED)) begin bad++; local_bad++; $display("FAIL rnd_cleared cyc=%0d got=%b", c, o_cleared); end
            if (o_landed !== (m_phase == P_LANDED)) begin bad++; local_bad++; $display("FAIL rnd_landed cyc=%0d got=%b", c, o_landed); end
            if (local_bad > 20) break;
        end
        $display("test_random: mismatching cycles in this run=%0d", local_bad);
    endtask

    task automatic test_async_reset();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        run_frames(5, 1'b0, 1'b0, 0);
        total += 1;
        if (o_desc !== 1'b1) begin bad++; $display("FAIL arst_pre_desc got=%b want=1", o_desc); end
        @(negedge clk);
        i_sof = 1'b0; i_hr = 1'b0;
        #2 resetN = 1'b0;
        #1;
        total += 6;
        if (o_desc !== 1'b0)  begin bad++; $display("FAIL arst_desc got=%b want=0", o_desc); end
        if (o_right !== 1'b0) begin bad++; $display("FAIL arst_right got=%b want=0", o_right); end
        if (o_alive !== 6'd0) begin bad++; $display("FAIL arst_alive got=%0d want=0", o_alive); end
        if (o_speed !== 4'd0) begin bad++; $display("FAIL arst_speed got=%0d want=0", o_speed); end
        if (o_step !== 1'b0)  begin bad++; $display("FAIL arst_step got=%b want=0", o_step); end
        if (o_cleared !== 1'b0 || o_landed !== 1'b0) begin bad++; $display("FAIL arst_flags got=%b%b want=00", o_cleared, o_landed); end
        model_reset();
        @(negedge clk);
        resetN = 1'b1;
        run_frames(40, 1'b0, 1'b0, 0);
        total += 1;
        if (o_alive !== 6'd0 || o_desc !== 1'b0) begin bad++; $display("FAIL arst_idle alive=%0d desc=%b want idle", o_alive, o_desc); end
        $display("test_async_reset: outputs cleared mid-descend");
    endtask

    task automatic test_final_sprint();
`ifdef INVADER_MARCH_FINAL_SPRINT_EN
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int k = 0; k < 31; k++) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        clear_counts();
        run_frames(10, 1'b0, 1'b0, 0);
        total += 2;
        if (steps_seen !== steps_exp) begin bad++; $display("FAIL sprint_steps got=%0d want=%0d", steps_seen, steps_exp); end
        if (steps_seen < 4) begin bad++; $display("FAIL sprint_rate got=%0d want>=4", steps_seen); end
        $display("test_final_sprint: steps in 10 frames=%0d", steps_seen);
`else
        $display("test_final_sprint: feature not built");
`endif
    endtask

    initial begin
        model_reset();
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        resetN = 1'b1;
        test_march();
        test_speed();
        test_edge();
        test_clear();
        test_landed();
        test_final_sprint();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
